// File: rtl/debug_step_master.sv
// Avalon-MM initiator for the core's debug CSR port: expands READ/WRITE/STEP/SNAPSHOT
// commands into CSR bus sequences and streams the results back as 32-bit words.
module debug_step_master #(
    parameter int POLL_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [6:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    output logic        rsp_err,
    output logic [6:0]  m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    output logic        busy
);

    localparam int PW_RAW = $clog2(POLL_LIMIT + 1);
    localparam int PW     = (PW_RAW > 11) ? PW_RAW : 11;
    localparam logic [PW-1:0] POLL_MAX = PW'(POLL_LIMIT);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_RD      = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_EVAL    = 3'd4;
    localparam logic [2:0] S_RSP     = 3'd5;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;

    // STEP sequence positions; SNAPSHOT uses 0..4 as its read index
    localparam logic [2:0] SQ_EN      = 3'd0;
    localparam logic [2:0] SQ_CNT     = 3'd1;
    localparam logic [2:0] SQ_POLL    = 3'd2;
    localparam logic [2:0] SQ_RB0     = 3'd3;
    localparam logic [2:0] SQ_RB_LAST = 3'd7;

    localparam logic [6:0] A_CYC_LO   = 7'h00;
    localparam logic [6:0] A_CYC_HI   = 7'h04;
    localparam logic [6:0] A_STEP_EN  = 7'h08;
    localparam logic [6:0] A_STEPS    = 7'h0C;
    localparam logic [6:0] A_INSTR_IF = 7'h10;
    localparam logic [6:0] A_VSTALL   = 7'h24;
    localparam logic [6:0] A_ICNT_LO  = 7'h28;
    localparam logic [6:0] A_ICNT_HI  = 7'h2C;

    logic [2:0]    r_state;
    logic [1:0]    r_op;
    logic [2:0]    r_seq;
    logic [31:0]   r_n;
    logic [PW-1:0] r_poll_cnt;
    logic [6:0]    r_m_address;
    logic [31:0]   r_m_writedata;
    logic [31:0]   r_rsp_data;
    logic          r_rsp_last;
    logic          r_rsp_err;

    logic          w_accept;
    logic          w_polling;
    logic          w_is_last;
    logic [2:0]    w_seq_inc;
    logic [6:0]    w_cmd_addr;

    function automatic logic seq_is_last(input logic [1:0] op, input logic [2:0] seq);
        case (op)
            OP_STEP: return seq == SQ_RB_LAST;
            2'b11:   return seq == 3'd4;
            default: return 1'b1;
        endcase
    endfunction

    // Address of the read that follows a handshaken response word
    function automatic logic [6:0] seq_addr(input logic [1:0] op, input logic [2:0] seq);
        logic [2:0] k;
        k = seq - SQ_RB0;
        if (op == OP_STEP)
            return A_INSTR_IF + {2'b00, k, 2'b00};
        case (seq)
            3'd0:    return A_CYC_LO;
            3'd1:    return A_CYC_HI;
            3'd2:    return A_ICNT_LO;
            3'd3:    return A_ICNT_HI;
            default: return A_VSTALL;
        endcase
    endfunction

    // Low address bits are dropped so every access is word aligned
    assign w_cmd_addr = {cmd_addr[6:2], cmd_addr[1:0] & 2'b00};
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_polling  = (r_op == OP_STEP) && (r_seq == SQ_POLL);
    assign w_is_last  = seq_is_last(r_op, r_seq);
    assign w_seq_inc  = r_seq + 3'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_op          <= 2'b00;
            r_seq         <= 3'd0;
            r_n           <= 32'd0;
            r_poll_cnt    <= '0;
            r_m_address   <= 7'd0;
            r_m_writedata <= 32'd0;
            r_rsp_data    <= 32'd0;
            r_rsp_last    <= 1'b0;
            r_rsp_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op       <= cmd_op;
                        r_n        <= cmd_data;
                        r_seq      <= 3'd0;
                        r_poll_cnt <= '0;
                        r_rsp_last <= 1'b0;
                        r_rsp_err  <= 1'b0;
                        case (cmd_op)
                            OP_READ: begin
                                r_m_address <= w_cmd_addr;
                                r_state     <= S_RD;
                            end
                            OP_WRITE: begin
                                r_m_address   <= w_cmd_addr;
                                r_m_writedata <= cmd_data;
                                r_state       <= S_WR;
                            end
                            OP_STEP: begin
                                if (cmd_data != 32'd0) begin
                                    r_m_address   <= A_STEP_EN;
                                    r_m_writedata <= 32'd1;
                                    r_state       <= S_WR;
                                end else begin
                                    r_seq       <= SQ_RB0;
                                    r_m_address <= A_INSTR_IF;
                                    r_state     <= S_RD;
                                end
                            end
                            default: begin
                                r_m_address <= A_CYC_LO;
                                r_state     <= S_RD;
                            end
                        endcase
                    end
                end
                S_WR: begin
                    if (r_op == OP_WRITE) begin
                        r_rsp_data <= 32'd0;
                        r_rsp_last <= 1'b1;
                        r_rsp_err  <= 1'b0;
                        r_state    <= S_RSP;
                    end else if (r_seq == SQ_EN) begin
                        r_seq         <= SQ_CNT;
                        r_m_address   <= A_STEPS;
                        r_m_writedata <= r_n;
                        r_state       <= S_WR;
                    end else begin
                        r_seq       <= SQ_POLL;
                        r_m_address <= A_STEPS;
                        r_state     <= S_RD;
                    end
                end
                S_RD: begin
                    r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    r_rsp_data <= m_readdata;
                    if (w_polling) begin
                        r_poll_cnt <= r_poll_cnt + 1'b1;
                        r_state    <= S_EVAL;
                    end else begin
                        r_rsp_last <= w_is_last;
                        r_rsp_err  <= 1'b0;
                        r_state    <= S_RSP;
                    end
                end
                S_EVAL: begin
                    // rsp_data already holds the value of the poll just read
                    if (r_rsp_data == 32'd0) begin
                        r_seq       <= SQ_RB0;
                        r_m_address <= A_INSTR_IF;
                        r_state     <= S_RD;
                    end else if (r_poll_cnt < POLL_MAX) begin
                        r_state <= S_RD;
                    end else begin
                        r_rsp_last <= 1'b1;
                        r_rsp_err  <= 1'b1;
                        r_state    <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        if (r_rsp_last) begin
                            r_rsp_last <= 1'b0;
                            r_rsp_err  <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_seq       <= w_seq_inc;
                            r_m_address <= seq_addr(r_op, w_seq_inc);
                            r_state     <= S_RD;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = (r_state == S_IDLE) && !reset;
    assign busy        = (r_state != S_IDLE);
    assign m_read      = (r_state == S_RD);
    assign m_write     = (r_state == S_WR);
    assign m_address   = r_m_address;
    assign m_writedata = r_m_writedata;
    assign rsp_valid   = (r_state == S_RSP);
    assign rsp_data    = r_rsp_data;
    assign rsp_last    = r_rsp_last;
    assign rsp_err     = r_rsp_err;

endmodule

// File: tb/tb_debug_step_master.sv
// Directed bench for debug_step_master: CSR slave with a manual_steps countdown model,
// a vector table of commands plus hand-written stall and reset sequences.
module tb_debug_step_master;

    localparam int POLL_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [6:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        rsp_err;
    logic [6:0]  m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;
    logic        busy;

    debug_step_master #(.POLL_LIMIT(POLL_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_readdata(m_readdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // CSR slave: latency-1 reads; manual_steps counts down each cycle unless stuck
    logic [31:0] mem [32];
    logic        stuck = 1'b0;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
            mem[0]  <= 32'h1111_0000;
            mem[1]  <= 32'h0000_0022;
            mem[4]  <= 32'h0000_0013;
            mem[5]  <= 32'h0000_0023;
            mem[6]  <= 32'h0000_0033;
            mem[7]  <= 32'h0000_0043;
            mem[8]  <= 32'h0000_0053;
            mem[9]  <= 32'h0000_0009;
            mem[10] <= 32'hA0A0_0001;
            mem[11] <= 32'hB0B0_0002;
            m_readdata <= 32'h0;
        end else begin
            if (m_read)
                m_readdata <= (stuck && m_address == 7'h0C) ? 32'd5 : mem[m_address[6:2]];
            if (m_write)
                mem[m_address[6:2]] <= m_writedata;
            else if (!stuck && mem[3] != 32'd0)
                mem[3] <= mem[3] - 32'd1;
        end
    end

    typedef struct { bit wr; logic [6:0] addr; logic [31:0] wd; int cyc; } bus_t;
    bus_t bus_q[$];
    int   both_hi = 0;
    always @(negedge clk) begin
        if (m_read || m_write) bus_q.push_back('{m_write, m_address, m_writedata, cyc});
        if (m_read && m_write) both_hi <= both_hi + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, got, exp);
        end
    endtask

    task automatic expired(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    logic [31:0] rd [8];
    bit          re [8];
    int          t_hs [8];
    int          n_rsp, t_acc, t_rsp, bus_base;
    bit          rdy_after;
    logic [33:0] stall_v;
    int          stall_chg, stall_bus;

    task automatic run_cmd(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                           input int stall_idx, input int stall_len);
        int guard;
        bit done;
        int scnt;
        n_rsp = 0; t_rsp = -1; t_acc = -1; stall_chg = 0; stall_bus = 0; stall_v = '0; scnt = 0;
        rdy_after = 1'b0;
        bus_base = bus_q.size();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            expired("cmd_ready_wait");
            return;
        end
        t_acc = cyc;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        done = 1'b0;
        guard = 0;
        while (!done && guard < 500) begin
            @(negedge clk);
            guard++;
            if (rsp_valid) begin
                if (t_rsp < 0) t_rsp = cyc;
                if (n_rsp == stall_idx && scnt < stall_len) begin
                    if (scnt == 0) stall_v = {rsp_last, rsp_err, rsp_data};
                    else if ({rsp_last, rsp_err, rsp_data} !== stall_v) stall_chg++;
                    if (m_read || m_write) stall_bus++;
                    rsp_ready = 1'b0;
                    scnt++;
                end else begin
                    rsp_ready = 1'b1;
                    if (n_rsp < 8) begin
                        rd[n_rsp]   = rsp_data;
                        re[n_rsp]   = rsp_err;
                        t_hs[n_rsp] = cyc;
                    end
                    n_rsp++;
                    if (rsp_last) done = 1'b1;
                end
            end
        end
        rsp_ready = 1'b1;
        if (!done) expired("rsp_wait");
        @(negedge clk);
        rdy_after = cmd_ready;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [31:0] data;
        bit          stk;
        int          n;
        logic [31:0] d0;
        logic [31:0] dl;
        bit          err;
        int          nbus;
    } vec_t;

    localparam int NV = 10;
    vec_t vec [NV];
    int   vbase [NV];

    logic [6:0]  step_addr_exp [9] = '{7'h08, 7'h0C, 7'h0C, 7'h0C, 7'h10, 7'h14, 7'h18, 7'h1C, 7'h20};
    bit          step_wr_exp   [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [6:0]  snap_addr_exp [5] = '{7'h00, 7'h04, 7'h28, 7'h2C, 7'h24};
    logic [31:0] snap_data_exp [5] = '{32'h1111_0000, 32'h0000_0022, 32'hA0A0_0001, 32'hB0B0_0002, 32'h0000_0009};

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, rst_rsp, b;
        bit err_other;
        logic [6:0] a;

        //          op     addr   data           stk  n  d0            dl            err nbus
        vec[0] = '{2'b01, 7'h40, 32'hDEADBEEF, 1'b0, 1, 32'h0,        32'h0,        1'b0, 1};
        vec[1] = '{2'b00, 7'h40, 32'h0,        1'b0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1};
        vec[2] = '{2'b00, 7'h13, 32'h0,        1'b0, 1, 32'h13,       32'h13,       1'b0, 1};
        vec[3] = '{2'b01, 7'h7F, 32'h12345678, 1'b0, 1, 32'h0,        32'h0,        1'b0, 1};
        vec[4] = '{2'b00, 7'h7C, 32'h0,        1'b0, 1, 32'h12345678, 32'h12345678, 1'b0, 1};
        vec[5] = '{2'b00, 7'h24, 32'h0,        1'b0, 1, 32'h9,        32'h9,        1'b0, 1};
        vec[6] = '{2'b10, 7'h00, 32'd0,        1'b0, 5, 32'h13,       32'h53,       1'b0, 5};
        vec[7] = '{2'b10, 7'h00, 32'd3,        1'b0, 5, 32'h13,       32'h53,       1'b0, 9};
        vec[8] = '{2'b10, 7'h00, 32'd7,        1'b1, 1, 32'h5,        32'h5,        1'b1, 6};
        vec[9] = '{2'b11, 7'h00, 32'h0,        1'b0, 5, 32'h1111_0000, 32'h9,       1'b0, 5};

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 7'h0; cmd_data = 32'h0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_flags", 32'({rsp_last, rsp_err}), 32'd0);
        chk("rst_strobes", 32'({m_read, m_write}), 32'd0);
        chk("rst_m_address", 32'(m_address), 32'd0);
        chk("rst_m_writedata", m_writedata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < NV; i++) begin
            stuck = vec[i].stk;
            run_cmd(vec[i].op, vec[i].addr, vec[i].data, -1, 0);
            vbase[i] = bus_base;
            $display("[TB] vec %0d op=%0d addr=0x%02h data=0x%08h words=%0d bus_ops=%0d first=0x%08h",
                     i, vec[i].op, vec[i].addr, vec[i].data, n_rsp, bus_q.size() - bus_base, rd[0]);
            idx = (n_rsp > 0 && n_rsp <= 8) ? n_rsp - 1 : 0;
            err_other = 1'b0;
            for (int k = 0; k < idx; k++) err_other |= re[k];
            chk($sformatf("v%0d_nwords", i), 32'(n_rsp), 32'(vec[i].n));
            chk($sformatf("v%0d_data_first", i), rd[0], vec[i].d0);
            chk($sformatf("v%0d_data_last", i), rd[idx], vec[i].dl);
            chk($sformatf("v%0d_err_last", i), 32'(re[idx]), 32'(vec[i].err));
            chk($sformatf("v%0d_err_other", i), 32'(err_other), 32'd0);
            chk($sformatf("v%0d_nbus", i), 32'(bus_q.size() - bus_base), 32'(vec[i].nbus));
            chk($sformatf("v%0d_ready_after", i), 32'(rdy_after), 32'd1);
            if ((vec[i].op == 2'b00 || vec[i].op == 2'b01) && bus_q.size() > bus_base) begin
                a = vec[i].addr;
                chk($sformatf("v%0d_bus_addr", i), 32'(bus_q[bus_base].addr), 32'({a[6:2], 2'b00}));
                chk($sformatf("v%0d_bus_kind", i), 32'(bus_q[bus_base].wr), 32'(vec[i].op == 2'b01));
                chk($sformatf("v%0d_bus_cycle", i), 32'(bus_q[bus_base].cyc - t_acc), 32'd1);
                chk($sformatf("v%0d_rsp_cycle", i), 32'(t_rsp - t_acc), (vec[i].op == 2'b00) ? 32'd3 : 32'd2);
                if (vec[i].op == 2'b01)
                    chk($sformatf("v%0d_bus_wdata", i), bus_q[bus_base].wd, vec[i].data);
            end
            if (vec[i].op == 2'b10 && vec[i].n == 5)
                for (int k = 0; k < n_rsp && k < 5; k++)
                    chk($sformatf("v%0d_readback%0d", i, k), rd[k], 32'h13 + 32'(16 * k));
        end
        stuck = 1'b0;

        // STEP 3: enable write, count write, two polls, then the five pipeline reads
        for (int k = 0; k < 9; k++) begin
            b = vbase[7] + k;
            if (b < bus_q.size()) begin
                chk($sformatf("step3_addr%0d", k), 32'(bus_q[b].addr), 32'(step_addr_exp[k]));
                chk($sformatf("step3_kind%0d", k), 32'(bus_q[b].wr), 32'(step_wr_exp[k]));
            end else expired($sformatf("step3_bus%0d", k));
        end
        if (vbase[7] + 1 < bus_q.size()) begin
            chk("step3_en_wdata", bus_q[vbase[7]].wd, 32'd1);
            chk("step3_n_wdata", bus_q[vbase[7] + 1].wd, 32'd3);
        end

        // SNAPSHOT with 10 cycles of backpressure on the second word
        run_cmd(2'b11, 7'h00, 32'h0, 1, 10);
        $display("[TB] snapshot stalled words=%0d bus_ops=%0d held=0x%09h", n_rsp, bus_q.size() - bus_base, stall_v);
        chk("snap_nwords", 32'(n_rsp), 32'd5);
        for (int k = 0; k < 5 && k < n_rsp; k++)
            chk($sformatf("snap_data%0d", k), rd[k], snap_data_exp[k]);
        for (int k = 0; k < 5; k++) begin
            b = bus_base + k;
            if (b < bus_q.size())
                chk($sformatf("snap_addr%0d", k), 32'(bus_q[b].addr), 32'(snap_addr_exp[k]));
            else expired($sformatf("snap_bus%0d", k));
        end
        chk("snap_held_word", stall_v[31:0], 32'h0000_0022);
        chk("snap_held_flags", 32'(stall_v[33:32]), 32'd0);
        chk("snap_held_changes", 32'(stall_chg), 32'd0);
        chk("snap_bus_in_stall", 32'(stall_bus), 32'd0);
        if (bus_base + 2 < bus_q.size())
            chk("snap_next_op_cycle", 32'(bus_q[bus_base + 2].cyc - t_hs[1]), 32'd1);

        // Reset pulse while the STEP poll loop is reading manual_steps
        stuck = 1'b1;
        rst_rsp = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 7'h0; cmd_data = 32'd9;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) rst_rsp++;
        end
        chk("poll_before_reset", 32'({m_read, m_address}), 32'({1'b1, 7'h0C}));
        reset = 1'b1;
        @(negedge clk);
        if (rsp_valid) rst_rsp++;
        chk("reset_strobes", 32'({m_read, m_write}), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        reset = 1'b0;
        stuck = 1'b0;
        @(negedge clk);
        if (rsp_valid) rst_rsp++;
        chk("post_reset_ready", 32'(cmd_ready), 32'd1);
        chk("reset_no_partial_rsp", 32'(rst_rsp), 32'd0);
        $display("[TB] reset during poll: responses seen=%0d", rst_rsp);

        run_cmd(2'b00, 7'h10, 32'h0, -1, 0);
        $display("[TB] read after reset words=%0d data=0x%08h", n_rsp, rd[0]);
        chk("post_reset_read_n", 32'(n_rsp), 32'd1);
        chk("post_reset_read_data", rd[0], 32'h13);
        chk("post_reset_read_lat", 32'(t_rsp - t_acc), 32'd3);

        chk("read_write_overlap", 32'(both_hi), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_step_master.md
# debug_step_master

Avalon-MM initiator for the core's debug CSR slave port (7-bit byte address, 32-bit data, fixed read latency 1, no waitrequest). It sits on the JTAG/host side and turns single commands into CSR transaction sequences: raw read, raw write, N-cycle single-step with pipeline readback, and performance-counter snapshot. Results are returned as a stream of 32-bit response words.

## Interface
- POLL_LIMIT, 1024, maximum number of `manual_steps` poll reads per STEP before timeout (≥1).
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid&cmd_ready.
- cmd_op  in  2  command: 00 READ, 01 WRITE, 10 STEP, 11 SNAPSHOT.
- cmd_addr  in  7  CSR byte address for READ/WRITE; bits [1:0] forced to 00 on the bus.
- cmd_data  in  32  write data (WRITE) or step count N (STEP).
- rsp_valid  out  1  response word present, held until rsp_ready.
- rsp_ready  in  1  consumer accepts the word.
- rsp_data  out  32  response word.
- rsp_last  out  1  final word of the current command.
- rsp_err  out  1  STEP poll timeout; valid with rsp_last.
- m_address  out  7  CSR byte address.
- m_read  out  1  single-cycle read strobe.
- m_write  out  1  single-cycle write strobe.
- m_writedata  out  32  write data.
- m_readdata  in  32  valid in the cycle after m_read.
- busy  out  1  high in any state other than IDLE.

## Operation
- CSR map (byte address): 0x00/0x04 cycle lo/hi; 0x08 manual_step_en; 0x0C manual_steps; 0x10–0x20 instr_if, instr_de, instr_ex, instr_mem, instr_wb; 0x24 vstall_cnt; 0x28/0x2C instr_cnt lo/hi; 0x40–0x7C scratch.
- State machine states:
  - IDLE: accept a command, then go to the first bus op.
  - WR: m_write for 1 cycle.
  - RD: m_read for 1 cycle.
  - RD_WAIT: sample m_readdata.
  - EVAL: poll compare.
  - RSP: hold a word until the handshake completes.
  - Command progress is held in a sequence index register.
- READ: RD(addr) → RD_WAIT → RSP (data=readdata, last=1).
- WRITE: WR(addr, cmd_data) → RSP (data=0, last=1).
- STEP N, N≠0:
  - Write 0x08←1, then write 0x0C←N.
  - Poll loop: read 0x0C, then EVAL.
    - readdata==0: readback phase.
    - readdata≠0 and poll count <POLL_LIMIT: read again.
    - Otherwise: one RSP (data=last polled value, err=1, last=1) and return to IDLE.
  - Readback phase: for addr 0x10,0x14,0x18,0x1C,0x20 in order, RD → RD_WAIT → RSP each; last=1 only on 0x20.
  - manual_step_en is left at 1, so the core stays halted after STEP.
- STEP N=0: no writes and no polls; only the 5-word readback.
- SNAPSHOT: read 0x00, 0x04, 0x28, 0x2C, 0x24, one RSP each in that order; last on 0x24.
- No bus op is issued while in RSP; backpressure fully stalls the sequence.
- m_read and m_write are never high in the same cycle.
- Between strobes, m_address and m_writedata hold their last values.
- rsp_err=0 on every word except a timeout response.

## Timing
- Reset values:
  - cmd_ready=0 during reset, 1 from the first cycle after.
  - rsp_valid, rsp_last, rsp_err, rsp_data=0.
  - m_read, m_write=0; m_address, m_writedata=0.
  - busy=0.
  - Sequence and poll counters =0.
- Command accepted at cycle T:
  - READ: m_read at T+1; readdata captured at end of T+2; rsp_valid from T+3.
  - WRITE: m_write at T+1; rsp_valid from T+2.
- Each poll iteration costs 3 cycles (RD, RD_WAIT, EVAL).
- After the response is accepted (rsp_valid&rsp_ready at cycle R):
  - Next bus op issues at R+1.
  - For the final word, cmd_ready=1 at R+1.
- rsp_data, rsp_last and rsp_err are stable while rsp_valid is high and rsp_ready is low.
- Reset mid-command: the command is abandoned. In the cycle after reset is sampled, all strobes and rsp_valid are 0; no partial response is emitted.
- Poll counter is 11+ bits wide, sized for POLL_LIMIT. It clears on every command accept and never wraps before the timeout compare.

## Test plan
- READ 0x10, slave returns 0x00000013 → m_read with m_address=0x10 at T+1 only; rsp_valid at T+3 with data 0x13, last=1, err=0.
- WRITE 0x40 data 0xDEADBEEF → single m_write cycle with those values; ack word data=0, last=1. A following READ 0x40 returns 0xDEADBEEF.
- STEP N=3, core model decrements manual_steps once per cycle:
  - Writes 0x08←1 then 0x0C←3, followed by polls of 0x0C.
  - Then 5 reads 0x10..0x20 in order.
  - Fifth response has last=1, err=0.
- STEP N=7, POLL_LIMIT=4, manual_steps stuck at 5 → exactly 4 reads of 0x0C, then one response data=5, err=1, last=1; cmd_ready high afterwards.
- SNAPSHOT, rsp_ready low for 10 cycles on the second word:
  - rsp_data holds the cycle hi word; no m_read occurs during the stall.
  - Word order: 0x00, 0x04, 0x28, 0x2C, 0x24.
- Reset pulse during the STEP poll loop → m_read, m_write and rsp_valid are 0 the next cycle; cmd_ready=1 after reset deasserts; a new READ completes normally.
